// File: rtl/instr_exec_reader_if.sv
// Instruction-register read port and result stream between instr_exec_reader
// (master) and the instruction register / result checker (slave).
interface instr_exec_reader_if;

  typedef struct packed {
    logic [3:0]  opc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] rez;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  logic [4:0]   read_pointer;
  instruction_t instruction_word;
  logic         res_valid;
  logic         res_ready;
  logic [4:0]   res_addr;
  logic [3:0]   res_opc;
  result_t      res_value;
  logic         res_err;

  modport master (
    output read_pointer,
    input  instruction_word,
    output res_valid,
    input  res_ready,
    output res_addr,
    output res_opc,
    output res_value,
    output res_err
  );

  modport slave (
    input  read_pointer,
    output instruction_word,
    input  res_valid,
    output res_ready,
    input  res_addr,
    input  res_opc,
    input  res_value,
    input  res_err
  );

endinterface

// File: rtl/instr_exec_reader.sv
// Walks a range of instruction-register entries, executes each instruction
// (including a serial signed divider) and streams one result record per entry.
module instr_exec_reader #(
  parameter int unsigned NUM_ENTRIES = 32,
  parameter int unsigned DIV_STEPS   = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [4:0]                 first_addr,
  input  logic [5:0]                 count,
  instr_exec_reader_if.master        bus,
  output logic                       busy,
  output logic                       done
);

  localparam logic [3:0] OpZero  = 4'd0;
  localparam logic [3:0] OpPassA = 4'd1;
  localparam logic [3:0] OpPassB = 4'd2;
  localparam logic [3:0] OpAdd   = 4'd3;
  localparam logic [3:0] OpSub   = 4'd4;
  localparam logic [3:0] OpMult  = 4'd5;
  localparam logic [3:0] OpDiv   = 4'd6;
  localparam logic [3:0] OpMod   = 4'd7;

  localparam logic [4:0] AddrMask = 5'(NUM_ENTRIES - 1);
  localparam logic [5:0] StepLast = 6'(DIV_STEPS);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StDivide,
    StOutput,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [5:0]  remain_q, remain_d;
  logic [3:0]  opc_q, opc_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [5:0]  step_q, step_d;
  logic        valid_q, valid_d;
  logic [4:0]  raddr_q, raddr_d;
  logic [3:0]  ropc_q, ropc_d;
  logic [63:0] rval_q, rval_d;
  logic        err_q, err_d;

  logic signed [63:0] sext_a, sext_b, prod;
  logic [31:0]        mag_a, mag_b;
  logic [32:0]        rem_shift, rem_diff;
  logic [63:0]        quot_signed, rem_signed;
  logic [63:0]        unused_rez;

  assign unused_rez = bus.instruction_word.rez;

  assign sext_a = {{32{op_a_q[31]}}, op_a_q};
  assign sext_b = {{32{op_b_q[31]}}, op_b_q};
  assign prod   = sext_a * sext_b;
  assign mag_a  = op_a_q[31] ? (~op_a_q + 32'd1) : op_a_q;
  assign mag_b  = op_b_q[31] ? (~op_b_q + 32'd1) : op_b_q;

  // Restoring step: bring in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem_q, quot_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quot_signed = (op_a_q[31] ^ op_b_q[31]) ? (64'd0 - {32'd0, quot_q}) : {32'd0, quot_q};
  assign rem_signed  = op_a_q[31] ? (64'd0 - {32'd0, rem_q}) : {32'd0, rem_q};

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    opc_d    = opc_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    step_d   = step_q;
    valid_d  = valid_q;
    raddr_d  = raddr_q;
    ropc_d   = ropc_q;
    rval_d   = rval_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          remain_d = count;
          if (count == 6'd0) begin
            state_d = StFinish;
          end else begin
            ptr_d   = first_addr;
            state_d = StFetch;
          end
        end
      end

      StFetch: begin
        opc_d   = bus.instruction_word.opc;
        op_a_d  = bus.instruction_word.op_a;
        op_b_d  = bus.instruction_word.op_b;
        state_d = StExec;
      end

      StExec: begin
        raddr_d = ptr_q;
        ropc_d  = opc_q;
        rval_d  = 64'd0;
        err_d   = 1'b0;
        valid_d = 1'b1;
        state_d = StOutput;
        case (opc_q)
          OpZero:  rval_d = 64'd0;
          OpPassA: rval_d = sext_a;
          OpPassB: rval_d = sext_b;
          OpAdd:   rval_d = sext_a + sext_b;
          OpSub:   rval_d = sext_a - sext_b;
          OpMult:  rval_d = prod;
          OpDiv, OpMod: begin
            if (op_b_q == 32'd0) begin
              err_d = 1'b1;
            end else begin
              valid_d = 1'b0;
              quot_d  = mag_a;
              rem_d   = 32'd0;
              dvsr_d  = mag_b;
              step_d  = 6'd0;
              state_d = StDivide;
            end
          end
          default: err_d = 1'b1;
        endcase
      end

      StDivide: begin
        if (step_q != StepLast) begin
          step_d = step_q + 6'd1;
          if (!rem_diff[32]) begin
            rem_d  = rem_diff[31:0];
            quot_d = {quot_q[30:0], 1'b1};
          end else begin
            rem_d  = rem_shift[31:0];
            quot_d = {quot_q[30:0], 1'b0};
          end
        end else begin
          rval_d  = (opc_q == OpDiv) ? quot_signed : rem_signed;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = StOutput;
        end
      end

      StOutput: begin
        if (bus.res_ready) begin
          valid_d  = 1'b0;
          remain_d = remain_q - 6'd1;
          if (remain_q != 6'd1) begin
            ptr_d   = (ptr_q + 5'd1) & AddrMask;
            state_d = StFetch;
          end else begin
            state_d = StFinish;
          end
        end
      end

      StFinish: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      ptr_q    <= 5'd0;
      remain_q <= 6'd0;
      opc_q    <= 4'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      quot_q   <= 32'd0;
      rem_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      step_q   <= 6'd0;
      valid_q  <= 1'b0;
      raddr_q  <= 5'd0;
      ropc_q   <= 4'd0;
      rval_q   <= 64'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      opc_q    <= opc_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      step_q   <= step_d;
      valid_q  <= valid_d;
      raddr_q  <= raddr_d;
      ropc_q   <= ropc_d;
      rval_q   <= rval_d;
      err_q    <= err_d;
    end
  end

  assign bus.read_pointer = ptr_q;
  assign bus.res_valid    = valid_q;
  assign bus.res_addr     = raddr_q;
  assign bus.res_opc      = ropc_q;
  assign bus.res_value    = rval_q;
  assign bus.res_err      = err_q;

  // FINISH still counts as busy so a start coinciding with done is dropped.
  assign busy = (state_q != StIdle);
  assign done = (state_q == StFinish);

endmodule
